relation_pair_gen: RTL
======================

Name: relation_pair_gen

Overview:
- Inverse of the team's 3-bit operand comparator: takes a requested relation code and enumerates every (A,B) operand pair satisfying it.
- Pairs stream out over a valid/ready handshake.
- Serves as the stimulus source for comparator regression benches and as a self-check engine in the lab series.
- Scans all 2^(2W) candidate pairs in fixed order, one candidate per cycle, then pulses done with a match count.

Parameters:
W, 3, operand width in bits; the candidate space is 2^(2W) pairs.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  begin an enumeration; sampled only in IDLE
rel_sel  input  3  relation: 0 gray, 1 excess_3, 2 more, 3 less, 4 no_relation, 5-7 illegal
a_out  output  W  operand A of the current pair
b_out  output  W  operand B of the current pair
out_valid  output  1  a_out/b_out hold a matching pair
out_ready  input  1  consumer accepts the pair when out_valid && out_ready
busy  output  1  enumeration in progress
done  output  1  one-cycle pulse at end of enumeration
err  output  1  one-cycle pulse, coincident with done, when rel_sel was illegal
match_cnt  output  2W+1  pairs emitted in the current or most recent run

Behaviour:
- Reset, asynchronous, active-low: state IDLE; all outputs 0; match_cnt 0; scan index 0.
- Relation definitions (unsigned operands):
  - gray: A^B has exactly one bit set.
  - excess_3: |A-B| == 3, computed without wrap-around.
  - more: A>B.
  - less: A<B.
  - no_relation: none of the four above hold, i.e. A==B.
- Scan order: index = {A,B}; A is the major field, B the minor field; runs 0 to 2^(2W)-1.
- IDLE:
  - start=1 latches rel_sel, clears match_cnt and index, sets busy; next state SCAN.
  - If the latched rel_sel is illegal, go to DONE instead; err=1 with done; no pairs emitted.
- SCAN evaluates one candidate per cycle:
  - On match: register the pair into a_out/b_out, set out_valid, go to HOLD.
  - On no match at the last index: go to DONE.
  - On no match otherwise: index+1 and stay in SCAN.
- HOLD:
  - a_out/b_out are stable while out_valid && !out_ready.
  - On handshake: out_valid drops next cycle and match_cnt increments. Then go to DONE if the index is the last, else index+1 and go to SCAN.
  - Back-to-back pairs therefore have at least one idle cycle between them.
- DONE: done=1 for exactly one cycle, busy drops in the same cycle, match_cnt holds; next state IDLE.
- Latency: the first candidate is evaluated the cycle after start; a match at index 0 gives out_valid two cycles after start.
- start while busy is ignored.
- rel_sel changes while busy are ignored, because the value is latched at start.
- out_ready while out_valid=0 has no effect.
- Reset mid-run aborts immediately to IDLE with all outputs 0; no done pulse.
- match_cnt does not wrap: maximum is 2^(2W) for any legal rel_sel, and width 2W+1 covers it.
- a_out/b_out keep the last emitted pair after out_valid drops; they are don't-care to consumers.

Decomposition:
- Shared package:
  - rel_sel encoding constants REL_GRAY=0, REL_EXCESS3=1, REL_MORE=2, REL_LESS=3, REL_NONE=4.
  - FSM state encoding: IDLE, SCAN, HOLD, DONE.
  - The excess distance constant, 3.
- One sub-module, pair_relation_eval: purely combinational.
  - Inputs: W-bit a and b.
  - Outputs: five relation flags per the definitions above.
  - Reused by benches as the scoreboard reference model.

Test Plan:
- rel_sel=1, out_ready tied 1 -> pairs in order (0,3),(1,4),(2,5),(3,0),(3,6),(4,1),(4,7),(5,2),(6,3),(7,4); done pulses; match_cnt=10; err=0.
- rel_sel=4, out_ready tied 1 -> (0,0),(1,1),...,(7,7); match_cnt=8. Repeat with rel_sel=0 -> first pairs (0,1),(0,2),(0,4),(1,0); match_cnt=24.
- rel_sel=2 with out_ready low for 5 cycles at the 3rd pair (2,1) -> a_out=2, b_out=1 stable throughout; no pair lost or duplicated; match_cnt=28.
- rel_sel=5 -> done and err both high for one cycle within 2 cycles of start; out_valid never asserts; match_cnt=0.
- start asserted again with rel_sel=3 mid-run of rel_sel=2 -> ignored; the run finishes with rel_sel=2 pairs only, match_cnt=28.
- rst_n low for 1 cycle while in HOLD -> all outputs 0 immediately with no done; a fresh start with rel_sel=1 reproduces the full 10-pair sequence.

Source files
------------

// File: rtl/relation_pair_gen_pkg.sv
// Shared definitions for the relation pair generator: relation codes,
// FSM state encoding and the excess distance.
package relation_pair_gen_pkg;

   localparam logic [2:0] REL_GRAY    = 3'd0;
   localparam logic [2:0] REL_EXCESS3 = 3'd1;
   localparam logic [2:0] REL_MORE    = 3'd2;
   localparam logic [2:0] REL_LESS    = 3'd3;
   localparam logic [2:0] REL_NONE    = 3'd4;

   localparam int unsigned EXCESS_DIST = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } state_t;

   // Codes above REL_NONE have no relation attached
   function automatic logic rel_legal(input logic [2:0] r);
      return r <= REL_NONE;
   endfunction

endpackage

// File: rtl/pair_relation_eval.sv
// Combinational evaluation of the five operand relations for one (a,b) pair.
module pair_relation_eval
   import relation_pair_gen_pkg::*;
#(
   parameter int unsigned W = 3
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         is_gray,
   output logic         is_excess3,
   output logic         is_more,
   output logic         is_less,
   output logic         is_none
);

   logic [W-1:0] x;
   logic [W-1:0] diff;

   // Relation flags; the distance is taken in the direction that cannot wrap
   always_comb begin
      x          = a ^ b;
      is_gray    = (x != '0) && ((x & (x - 1'b1)) == '0);
      is_more    = a > b;
      is_less    = a < b;
      diff       = is_more ? (a - b) : (b - a);
      is_excess3 = diff == W'(EXCESS_DIST);
      is_none    = !(is_gray || is_excess3 || is_more || is_less);
   end

endmodule

// File: rtl/relation_pair_gen.sv
// Enumerates every (A,B) operand pair satisfying a requested relation and
// streams them out over valid/ready, then pulses done with the match count.
module relation_pair_gen
   import relation_pair_gen_pkg::*;
#(
   parameter int unsigned W = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [2:0]     rel_sel,
   output logic [W-1:0]   a_out,
   output logic [W-1:0]   b_out,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           busy,
   output logic           done,
   output logic           err,
   output logic [2*W:0]   match_cnt
);

   state_t         state;
   logic [2:0]     rel_q;
   logic [2*W-1:0] idx;
   logic [W-1:0]   cand_a;
   logic [W-1:0]   cand_b;
   logic           last;
   logic           match;
   logic           f_gray, f_excess3, f_more, f_less, f_none;

   // A is the major field of the scan index, B the minor
   assign cand_a = idx[2*W-1:W];
   assign cand_b = idx[W-1:0];
   assign last   = &idx;

   pair_relation_eval #(
      .W (W)
   ) u_eval (
      .a          (cand_a),
      .b          (cand_b),
      .is_gray    (f_gray),
      .is_excess3 (f_excess3),
      .is_more    (f_more),
      .is_less    (f_less),
      .is_none    (f_none)
   );

   // Select the flag for the latched relation
   always_comb begin
      match = 1'b0;
      case (rel_q)
         REL_GRAY:    match = f_gray;
         REL_EXCESS3: match = f_excess3;
         REL_MORE:    match = f_more;
         REL_LESS:    match = f_less;
         REL_NONE:    match = f_none;
         default:     match = 1'b0;
      endcase
   end

   // Scan FSM with registered outputs; done/busy change on entry to DONE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rel_q     <= '0;
         idx       <= '0;
         a_out     <= '0;
         b_out     <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         match_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               err  <= 1'b0;
               if (start) begin
                  rel_q     <= rel_sel;
                  match_cnt <= '0;
                  idx       <= '0;
                  if (rel_legal(rel_sel)) begin
                     busy  <= 1'b1;
                     state <= SCAN;
                  end else begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     err   <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            SCAN: begin
               if (match) begin
                  a_out     <= cand_a;
                  b_out     <= cand_b;
                  out_valid <= 1'b1;
                  state     <= HOLD;
               end else if (last) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  match_cnt <= match_cnt + 1'b1;
                  if (last) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= SCAN;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               err   <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
